hc_stream_xor: RTL

Keystream consumer and data combiner for the HC stream cipher core. It requests keystream words from the core with a `next` pulse and collects each returned word on `s_valid` into a small prefetch FIFO. Each input data word is XORed with the oldest buffered keystream word, and the result goes out through a registered valid/ready stage. It sits between the cipher core and the byte/word datapath, so encryption and decryption are the same operation.

---
 rtl/hc_stream_xor.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hc_stream_xor.sv
// Keystream prefetch buffer and XOR combiner for the HC stream cipher core.
// Requests one keystream word at a time and XORs buffered words onto the data stream.
module hc_stream_xor #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        flush,
    output logic        core_next,
    input  logic [31:0] core_s,
    input  logic        core_s_valid,
    input  logic [31:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [31:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [4:0]  fill,
    output logic [31:0] word_count
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t          state_reg, state_next;
    logic            core_next_reg, core_next_next;
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [4:0]      fill_reg;
    logic [31:0]     dout_reg;
    logic            dout_valid_reg;
    logic [31:0]     word_count_reg;
    logic [31:0]     mem [DEPTH];
    logic            push, pop;

    assign din_ready  = (fill_reg != 5'd0) && (!dout_valid_reg || dout_ready) && !flush;
    assign pop        = din_valid && din_ready;
    assign core_next  = core_next_reg;
    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign fill       = fill_reg;
    assign word_count = word_count_reg;

    // A flush freezes the request decision for one cycle; only an outstanding
    // request is redirected to DRAIN so its word is dropped when it lands.
    always_comb begin
        state_next     = state_reg;
        core_next_next = 1'b0;
        push           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && !flush) state_next = REQ;
            end
            REQ: begin
                if (flush) begin
                    state_next = REQ;
                end else if (!enable) begin
                    state_next = IDLE;
                end else if (fill_reg < 5'(DEPTH)) begin
                    core_next_next = 1'b1;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (core_s_valid) begin
                    push       = !flush;
                    state_next = enable ? REQ : IDLE;
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (core_s_valid) state_next = enable ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            core_next_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            core_next_reg <= core_next_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= core_s;
    end

    // Pop is blocked during flush by din_ready, and push is suppressed, so flush wins cleanly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= 5'd0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= 5'd0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            fill_reg <= fill_reg + {4'd0, push} - {4'd0, pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_reg       <= 32'd0;
            dout_valid_reg <= 1'b0;
            word_count_reg <= 32'd0;
        end else if (pop) begin
            dout_reg       <= din ^ mem[rd_ptr_reg];
            dout_valid_reg <= 1'b1;
            word_count_reg <= word_count_reg + 32'd1;
        end else if (dout_ready) begin
            dout_valid_reg <= 1'b0;
        end
    end
endmodule
